ex_mem_skid: RTL

EX_MEM_SKID -- requirements
Module: ex_mem_skid

---
 rtl/ex_mem_skid.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_skid.sv
// Two-entry skid buffer between the EX and MEM stages. in_ready is registered so
// that MEM backpressure never reaches EX combinationally; an overflow trap squashes controls.
module ex_mem_skid (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_result,
   input  logic        in_ovf,
   input  logic [4:0]  in_rd,
   input  logic        in_regwrite,
   input  logic        in_memread,
   input  logic        in_memwrite,
   input  logic [31:0] in_store_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic        out_ovf,
   output logic [4:0]  out_rd,
   output logic        out_regwrite,
   output logic        out_memread,
   output logic        out_memwrite,
   output logic [31:0] out_store_data,
   input  logic        flush,
   input  logic        trap_en,
   output logic        ovf_exc
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

   typedef struct packed {
      logic [31:0] result;
      logic        zero;
      logic        ovf;
      logic [4:0]  rd;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic [31:0] store_data;
   } entry_t;

   function automatic entry_t clear_ctrl(input entry_t e);
      entry_t r;
      r          = e;
      r.regwrite = 1'b0;
      r.memread  = 1'b0;
      r.memwrite = 1'b0;
      return r;
   endfunction

   state_e state_q, state_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   entry_t cap;
   logic   in_ready_q, in_ready_d;
   logic   ovf_exc_q, ovf_exc_d;
   logic   trap, push, pop;

   assign trap      = trap_en && in_ovf;
   assign push      = in_valid && in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign pop       = out_valid && out_ready;

   // A trapped entry keeps its result/ovf for the handler but must not touch state.
   always_comb begin
      cap.result     = in_result;
      cap.zero       = (in_result == 32'h0);
      cap.ovf        = in_ovf;
      cap.rd         = in_rd;
      cap.regwrite   = in_regwrite;
      cap.memread    = in_memread;
      cap.memwrite   = in_memwrite;
      cap.store_data = in_store_data;
      if (trap) begin
         cap = clear_ctrl(cap);
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         head_d  = clear_ctrl(head_q);
      end else begin
         unique case (state_q)
            EMPTY: if (push) begin
               state_d = ONE;
               head_d  = cap;
            end
            ONE: begin
               if (push && pop) begin
                  head_d = cap;
               end else if (push) begin
                  state_d = FULL;
                  skid_d  = cap;
               end else if (pop) begin
                  state_d = EMPTY;
                  head_d  = clear_ctrl(head_q);
               end
            end
            FULL: if (pop) begin
               state_d = ONE;
               head_d  = skid_q;
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = (state_d != FULL);
      ovf_exc_d  = push && trap && !flush;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         head_q     <= '0;
         ovf_exc_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         head_q     <= head_d;
         ovf_exc_q  <= ovf_exc_d;
      end
   end

   // NOTE: the skid slot is data-only storage, never visible until written, so it has no reset.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

   assign in_ready       = in_ready_q;
   assign ovf_exc        = ovf_exc_q;
   assign out_result     = head_q.result;
   assign out_zero       = head_q.zero;
   assign out_ovf        = head_q.ovf;
   assign out_rd         = head_q.rd;
   assign out_regwrite   = head_q.regwrite;
   assign out_memread    = head_q.memread;
   assign out_memwrite   = head_q.memwrite;
   assign out_store_data = head_q.store_data;

endmodule
